rv_run_monitor: RTL and testbench
=================================

Name: rv_run_monitor

Overview:
- Synthesizable, parametrised run checker for the single-cycle RV32I core. It replaces hand-inspected waveform dumps with automatic pass/fail.
- Snoops the register-file write port and the PC. Compares successive writes to one watched register against a loadable table of expected values.
- Detects program end as a PC self-loop (jal x0,0) and reports pass/fail, a failure code and counters.
- Instantiated beside the core in the top-level bench; also usable on FPGA with the result routed to LEDs.

Parameters:
- XLEN, 32, data/PC width
- DEPTH, 16, expected-value table entries (power of 2)
- WATCH_REG, 3, architectural register checked (1..31)
- HALT_CYCLES, 4, consecutive cycles with unchanged PC that mean "halted" (>=2)
- MAX_CYCLES, 1024, timeout in cycles from start

Ports:
- clk, in, 1, clock; all logic on rising edge
- reset, in, 1, synchronous active-high reset
- start, in, 1, begin a run; honoured only in IDLE
- clear, in, 1, return to IDLE from any state; table contents kept
- exp_we, in, 1, table write strobe; honoured only in IDLE
- exp_addr, in, $clog2(DEPTH), table write address
- exp_data, in, XLEN, table write data
- exp_len, in, $clog2(DEPTH)+1, number of expected writes; sampled on accepted start
- rf_we, in, 1, core register-file write enable
- rf_rd, in, 5, core destination register
- rf_wdata, in, XLEN, core write-back data
- pc, in, XLEN, core current PC
- busy, out, 1, state==RUN
- done, out, 1, state is PASS or FAIL
- pass, out, 1, state==PASS
- fail_code, out, 3, 0 none, 1 mismatch, 2 missing writes, 3 misaligned PC, 4 extra write, 5 timeout
- match_cnt, out, $clog2(DEPTH)+1, expected writes matched so far
- cycle_cnt, out, $clog2(MAX_CYCLES)+1, cycles spent in RUN
- last_wdata, out, XLEN, most recent value written to WATCH_REG during RUN

Behaviour:
- Reset: state IDLE. All outputs, counters, pc_q and stable_cnt are 0. Table contents are undefined after reset.
- States: IDLE, RUN, PASS, FAIL. PASS and FAIL are sticky until clear or reset. Reset and clear take priority over everything else.
- IDLE:
  - exp_we writes exp_mem[exp_addr] <= exp_data.
  - start latches len_q <= exp_len, zeroes all counters, loads pc_q <= pc, and moves to RUN the next cycle.
  - start and exp_we in the same cycle: the write happens and the run starts.
- RUN, every cycle:
  - cycle_cnt++.
  - stable_cnt = (pc==pc_q) ? stable_cnt+1 : 0; then pc_q <= pc.
- Watched write: rf_we && rf_rd==WATCH_REG.
  - last_wdata <= rf_wdata.
  - If match_cnt >= len_q, fail with code 4.
  - Else if rf_wdata != exp_mem[match_cnt], fail with code 1.
  - Else match_cnt++.
- Writes with rf_rd==0 or rf_rd!=WATCH_REG are ignored.
- Halt: stable_cnt reaches HALT_CYCLES-1 while pc still equals pc_q. Go to PASS if match_cnt==len_q (including that cycle's matching write), else FAIL code 2.
- Timeout: cycle_cnt==MAX_CYCLES-1 with no other event, so FAIL code 5.
- Priority for simultaneous events in one cycle: code 1/4 > code 3 > halt outcome > code 5.
- Latency: the decision is visible on done/pass/fail_code one cycle after the triggering input edge.
- exp_len > DEPTH is clamped to DEPTH.
- exp_len==0 passes on halt if no watched write occurred.
- Counters freeze on leaving RUN. last_wdata holds.
- start or exp_we outside IDLE is ignored.

Optional Feature:
- Macro: RV_RUN_MONITOR_PC_ALIGN_EN.
- Defined: in RUN, pc[1:0]!=0 sends the block to FAIL code 3 the next cycle.
- Undefined: no alignment check; code 3 is never produced; the alignment logic is absent.

Test Plan:
- Load exp {5,10,15}, exp_len=3, WATCH_REG=3. Drive writes x3=5,10,15, then hold pc=0x40 for 4 cycles. Expect pass=1, fail_code=0, match_cnt=3, last_wdata=15.
- Same table, drive x3=5,11. Expect FAIL code 1 one cycle after the second write, match_cnt=1, last_wdata=11.
- exp_len=2 {1,2}, drive x3=1,2,3. Expect FAIL code 4. Separately, drive only x3=1 then halt: expect FAIL code 2.
- PC incrementing by 4 for MAX_CYCLES cycles with no halt. Expect FAIL code 5 and cycle_cnt=MAX_CYCLES-1.
- With the macro defined, pc=0x0000_0042 in RUN gives FAIL code 3. Assert the same pc plus a mismatching x3 write in one cycle: code 1 wins. Without the macro, the same pc has no effect.
- Assert reset mid-RUN: all outputs 0 next cycle. Assert clear in PASS: IDLE, table retained, and a restarted identical run passes again.

Source files
------------

// File: rtl/rv_run_monitor.sv
// rv_run_monitor: automatic pass/fail run checker for the single-cycle RV32I core
// Snoops the register-file write port and the PC, checks successive writes to
// WATCH_REG against a loadable table, and treats a PC self-loop as program end.
// Inputs : clk, reset (sync, active-high), start, clear, exp_we/exp_addr/exp_data
//          (table load), exp_len, rf_we/rf_rd/rf_wdata (core write port), pc.
// Outputs: busy, done, pass, fail_code (1 mismatch, 2 missing, 3 misaligned PC,
//          4 extra write, 5 timeout), match_cnt, cycle_cnt, last_wdata.
// Define RV_RUN_MONITOR_PC_ALIGN_EN to enable the PC alignment check (code 3).
module rv_run_monitor #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 16,
  parameter int WATCH_REG   = 3,
  parameter int HALT_CYCLES = 4,
  parameter int MAX_CYCLES  = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        clear,
  input  logic                        exp_we,
  input  logic [$clog2(DEPTH)-1:0]    exp_addr,
  input  logic [XLEN-1:0]             exp_data,
  input  logic [$clog2(DEPTH):0]      exp_len,
  input  logic                        rf_we,
  input  logic [4:0]                  rf_rd,
  input  logic [XLEN-1:0]             rf_wdata,
  input  logic [XLEN-1:0]             pc,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [2:0]                  fail_code,
  output logic [$clog2(DEPTH):0]      match_cnt,
  output logic [$clog2(MAX_CYCLES):0] cycle_cnt,
  output logic [XLEN-1:0]             last_wdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam int SW = $clog2(HALT_CYCLES) + 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PASS = 2'd2, FAIL = 2'd3;
  localparam logic [4:0] WR = 5'(WATCH_REG);
  localparam logic [SW-1:0] HALT_LAST = SW'(HALT_CYCLES - 2);
  localparam logic [CW-1:0] CYC_LAST = CW'(MAX_CYCLES - 1);
  localparam logic [AW:0] LEN_MAX = (AW + 1)'(DEPTH);
  logic [1:0] state;
  logic [XLEN-1:0] exp_mem [DEPTH];
  logic [AW:0] len_q, match_n;
  logic [XLEN-1:0] pc_q;
  logic [SW-1:0] stable_cnt;
  logic [CW-1:0] cycle_n;
  logic mis, same, watched, over, hit, bad, halt, tmo, fin;
  logic [2:0] code_n;
`ifdef RV_RUN_MONITOR_PC_ALIGN_EN
  assign mis = |pc[1:0];
`else
  assign mis = 1'b0;
`endif
  // halt fires on the cycle the unchanged-PC run reaches HALT_CYCLES-1,
  // so the final matching write of that same cycle still counts
  always_comb begin
    same    = pc == pc_q;
    watched = rf_we && rf_rd != 5'd0 && rf_rd == WR;
    over    = match_cnt >= len_q;
    hit     = watched && !over && rf_wdata == exp_mem[match_cnt[AW-1:0]];
    bad     = watched && !hit;
    match_n = match_cnt + (AW + 1)'(hit);
    cycle_n = cycle_cnt + 1'b1;
    halt    = same && stable_cnt == HALT_LAST;
    tmo     = cycle_n == CYC_LAST;
    fin     = bad || mis || halt || tmo;
    code_n  = bad ? (over ? 3'd4 : 3'd1) : mis ? 3'd3 :
              halt ? (match_n == len_q ? 3'd0 : 3'd2) : tmo ? 3'd5 : 3'd0;
  end
  always_ff @(posedge clk)
    if (!reset && !clear && state == IDLE && exp_we) exp_mem[exp_addr] <= exp_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fail_code  <= '0;
      len_q      <= '0;
      match_cnt  <= '0;
      cycle_cnt  <= '0;
      stable_cnt <= '0;
      pc_q       <= '0;
      last_wdata <= '0;
    end else if (clear) begin
      state     <= IDLE;
      fail_code <= '0;
    end else if (state == IDLE && start) begin
      state      <= RUN;
      len_q      <= exp_len > LEN_MAX ? LEN_MAX : exp_len;
      match_cnt  <= '0;
      cycle_cnt  <= '0;
      stable_cnt <= '0;
      pc_q       <= pc;
      last_wdata <= '0;
    end else if (state == RUN) begin
      cycle_cnt  <= cycle_n;
      stable_cnt <= same ? stable_cnt + 1'b1 : '0;
      pc_q       <= pc;
      match_cnt  <= match_n;
      if (watched) last_wdata <= rf_wdata;
      if (fin) begin
        state     <= code_n == 3'd0 ? PASS : FAIL;
        fail_code <= code_n;
      end
    end
  end
  assign busy = state == RUN;
  assign done = state[1];
  assign pass = state == PASS;
endmodule

// File: tb/tb_rv_run_monitor.sv
// tb_rv_run_monitor: scoreboard bench for rv_run_monitor with directed runs
module tb_rv_run_monitor;
  logic clk = 1'b0;
  logic reset, start, clear, exp_we, rf_we;
  logic [3:0] exp_addr;
  logic [31:0] exp_data, rf_wdata, pc;
  logic [4:0] exp_len, rf_rd;
  logic busy, done, pass;
  logic [2:0] fail_code;
  logic [4:0] match_cnt;
  logic [10:0] cycle_cnt;
  logic [31:0] last_wdata;
  rv_run_monitor dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data), .exp_len(exp_len),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .pc(pc),
    .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
    .match_cnt(match_cnt), .cycle_cnt(cycle_cnt), .last_wdata(last_wdata)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic p;
    logic [2:0] code;
    logic [4:0] m;
    logic [31:0] last;
    int cc;
    int at;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic done_q = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got code %0d expected no decision", fail_code);
      end else begin
        me = q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(me.at));
        chk("pass", pass, me.p);
        chk("fail_code", fail_code, me.code);
        chk("match_cnt", match_cnt, me.m);
        chk("last_wdata", last_wdata, me.last);
        chk("cycle_cnt", cycle_cnt, 64'(me.cc));
        chk("busy_at_done", busy, 0);
      end
    end
    done_q = done;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_res(input logic p, input int code, input int m, input int last, input int cc);
    exp_t e;
    e.p = p;
    e.code = code[2:0];
    e.m = m[4:0];
    e.last = last;
    e.cc = cc;
    e.at = cyc + 1;
    q.push_back(e);
  endtask
  task automatic wr(input int a, input int d);
    exp_addr = a[3:0];
    exp_data = d;
    exp_we = 1'b1;
    tick();
    exp_we = 1'b0;
  endtask
  task automatic go(input int len);
    pc = 32'h100;
    exp_len = len[4:0];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wrd(input int rd, input int d);
    rf_we = 1'b1;
    rf_rd = rd[4:0];
    rf_wdata = d;
    pc = pc + 4;
    tick();
    rf_we = 1'b0;
  endtask
  task automatic wx3(input int d);
    wrd(3, d);
  endtask
  task automatic halt_seq(input logic p, input int code, input int m, input int last, input int cc);
    pc = 32'h40;
    repeat (3) tick();
    expect_res(p, code, m, last, cc);
    tick();
  endtask
  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 20) begin
      tick();
      t++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask
  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_done", done, 0);
    chk("clear_busy", busy, 0);
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_done"}, done, 0);
    chk({n, "_pass"}, pass, 0);
    chk({n, "_code"}, fail_code, 0);
    chk({n, "_match"}, match_cnt, 0);
    chk({n, "_cycles"}, cycle_cnt, 0);
    chk({n, "_last"}, last_wdata, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1);
  end
  initial begin
    reset = 1'b1; start = 1'b0; clear = 1'b0; exp_we = 1'b0; rf_we = 1'b0;
    exp_addr = '0; exp_data = '0; exp_len = '0; rf_rd = '0; rf_wdata = '0; pc = '0;
    repeat (2) tick();
    reset = 1'b0;
    chk_zero("reset");
    // basic pass, ignored writes to x0 and x5
    wr(0, 5); wr(1, 10); wr(2, 15);
    go(3);
    wx3(5); wrd(0, 99); wx3(10); wrd(5, 99); wx3(15);
    halt_seq(1'b1, 0, 3, 15, 9);
    drain();
    repeat (2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sticky_pass", pass, 1);
    chk("sticky_busy", busy, 0);
    do_clear();
    // table kept across clear; table write during RUN ignored
    go(3);
    exp_we = 1'b1; exp_addr = 4'd0; exp_data = 32'd77;
    wx3(5);
    exp_we = 1'b0;
    wx3(10); wx3(15);
    halt_seq(1'b1, 0, 3, 15, 7);
    drain();
    do_clear();
    // mismatch on second write; writes in FAIL ignored
    go(3);
    wx3(5);
    expect_res(1'b0, 1, 1, 11, 2);
    wx3(11);
    drain();
    wx3(20);
    chk("fail_hold_last", last_wdata, 11);
    chk("fail_hold_match", match_cnt, 1);
    chk("fail_hold_code", fail_code, 1);
    chk("fail_hold_cycles", cycle_cnt, 2);
    do_clear();
    // extra write, then missing write
    wr(0, 1); wr(1, 2);
    go(2);
    wx3(1); wx3(2);
    expect_res(1'b0, 4, 2, 3, 3);
    wx3(3);
    drain();
    do_clear();
    go(2);
    wx3(1);
    halt_seq(1'b0, 2, 1, 1, 5);
    drain();
    do_clear();
    // empty expectation list
    go(0);
    halt_seq(1'b1, 0, 0, 0, 4);
    drain();
    do_clear();
    // exp_len 31 clamps to 16
    for (int i = 0; i < 16; i++) wr(i, i * 3 + 1);
    go(31);
    for (int i = 0; i < 16; i++) wx3(i * 3 + 1);
    halt_seq(1'b1, 0, 16, 46, 20);
    drain();
    do_clear();
    // timeout
    go(0);
    repeat (1022) begin
      pc = pc + 4;
      tick();
    end
    expect_res(1'b0, 5, 0, 0, 1023);
    pc = pc + 4;
    tick();
    drain();
    do_clear();
    // PC alignment
    wr(0, 5); wr(1, 10); wr(2, 15);
`ifdef RV_RUN_MONITOR_PC_ALIGN_EN
    go(3);
    pc = 32'h42;
    expect_res(1'b0, 3, 0, 0, 1);
    tick();
    drain();
    do_clear();
`else
    go(3);
    pc = 32'h42;
    tick();
    chk("align_ignored_busy", busy, 1);
    wx3(5); wx3(10); wx3(15);
    halt_seq(1'b1, 0, 3, 15, 8);
    drain();
    do_clear();
`endif
    go(3);
    pc = 32'h42;
    rf_we = 1'b1; rf_rd = 5'd3; rf_wdata = 32'd7;
    expect_res(1'b0, 1, 0, 7, 1);
    tick();
    rf_we = 1'b0;
    drain();
    do_clear();
    // reset mid-run
    go(3);
    wx3(5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero("midrun_reset");
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
